// File: rtl/mem_responder.sv
// Responder end of the core memory request interface: serves byte/wyde/tetra/octa
// requests from a 32-bit big-endian synchronous RAM. Octa accesses take two beats.
module mem_responder #(
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic              mem_error,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, BEAT1, WAIT1, BEAT2, WAIT2, DONE} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  state_t            state;
  logic [ADDR_W-2:0] req_octa_word;
  logic [1:0]        req_lane;
  logic [1:0]        req_size;
  logic              req_write;
  logic [31:0]       req_wdata_lo;
  logic [1:0]        wait_cnt;
  logic [31:0]       rd_hi;

  logic [ADDR_W+1:0] in_addr;
  logic              in_range;
  logic [1:0]        in_lane;
  logic [3:0]        in_be;
  logic [31:0]       in_wdata;
  logic [ADDR_W-1:0] in_word;
  logic [31:0]       lane;

  // First-beat RAM controls are decoded from the live request so they can be registered on entry to BEAT1.
  always_comb begin
    in_addr  = mem_address[ADDR_W+1:0];
    in_range = ~|mem_address[63:ADDR_W+2];
    in_lane  = 2'b00;
    in_be    = 4'b1111;
    in_wdata = mem_writedata[31:0];
    in_word  = in_addr[ADDR_W+1:2];
    case (mem_datasize)
      2'd0: begin
        in_lane  = in_addr[1:0];
        in_be    = 4'b1000 >> in_addr[1:0];
        in_wdata = {4{mem_writedata[7:0]}};
      end
      2'd1: begin
        in_lane  = {in_addr[1], 1'b0};
        in_be    = in_addr[1] ? 4'b0011 : 4'b1100;
        in_wdata = {2{mem_writedata[15:0]}};
      end
      2'd2: ;
      default: begin
        in_wdata = mem_writedata[63:32];
        in_word  = {in_addr[ADDR_W+1:3], 1'b0};
      end
    endcase
  end

  always_comb begin
    lane = ram_rdata;
    case (req_size)
      2'd0: begin
        case (req_lane)
          2'd0:    lane = {24'h0, ram_rdata[31:24]};
          2'd1:    lane = {24'h0, ram_rdata[23:16]};
          2'd2:    lane = {24'h0, ram_rdata[15:8]};
          default: lane = {24'h0, ram_rdata[7:0]};
        endcase
      end
      2'd1:    lane = req_lane[1] ? {16'h0, ram_rdata[15:0]} : {16'h0, ram_rdata[31:16]};
      default: lane = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem_done      <= 1'b0;
      mem_error     <= 1'b0;
      mem_readdata  <= '0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_be        <= '0;
      ram_wdata     <= '0;
      req_octa_word <= '0;
      req_lane      <= '0;
      req_size      <= '0;
      req_write     <= 1'b0;
      req_wdata_lo  <= '0;
      wait_cnt      <= '0;
      rd_hi         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            req_octa_word <= in_addr[ADDR_W+1:3];
            req_lane      <= in_lane;
            req_size      <= mem_datasize;
            req_write     <= mem_write;
            req_wdata_lo  <= mem_writedata[31:0];
            if (!in_range) begin
              mem_done     <= 1'b1;
              mem_error    <= 1'b1;
              mem_readdata <= '0;
              state        <= DONE;
            end else begin
              ram_en    <= 1'b1;
              ram_we    <= mem_write;
              ram_addr  <= in_word;
              ram_be    <= in_be;
              ram_wdata <= in_wdata;
              state     <= BEAT1;
            end
          end
        end
        BEAT1: begin
          if (req_write && req_size == 2'd3) begin
            ram_addr  <= {req_octa_word, 1'b1};
            ram_wdata <= req_wdata_lo;
            state     <= BEAT2;
          end else if (req_write) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            mem_done <= 1'b1;
            state    <= DONE;
          end else begin
            ram_en   <= 1'b0;
            wait_cnt <= WAIT_INIT;
            state    <= WAIT1;
          end
        end
        WAIT1: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (req_size == 2'd3) begin
            rd_hi    <= ram_rdata;
            ram_en   <= 1'b1;
            ram_addr <= {req_octa_word, 1'b1};
            state    <= BEAT2;
          end else begin
            mem_readdata <= {32'h0, lane};
            mem_done     <= 1'b1;
            state        <= DONE;
          end
        end
        BEAT2: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (req_write) begin
            mem_done <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT2;
          end
        end
        WAIT2: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            mem_readdata <= {rd_hi, ram_rdata};
            mem_done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          mem_done  <= 1'b0;
          mem_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
